ysyx_23060187_alu_arbiter: RTL
==============================

# ysyx_23060187_alu_arbiter

Shares the single 32-bit ALU between two requesters (requester 0: EXU operand path, requester 1: address/PC-increment path) using valid/ready handshakes and round-robin arbitration. Accepted operations are evaluated on the shared ALU and the outcome is captured in a one-entry response register that holds until the consumer accepts it. The block sits between the decode/issue logic and the ALU instance it owns.

## Interface
- PRIO_INIT, 0, requester that holds priority after reset (0 or 1)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid / req1_valid  input  1  requester has an operation pending
- req0_ready / req1_ready  output  1  operation accepted this cycle when valid&&ready
- req0_op1, req0_op2 / req1_op1, req1_op2  input  32  operands
- req0_ctrl / req1_ctrl  input  2  ALU op; 2'b00 = add, others = null op
- resp_valid  output  1  response register holds a result
- resp_ready  input  1  consumer takes response when valid&&ready
- resp_id  output  1  requester that issued the held result
- resp_result  output  32  held ALU result
- resp_zero  output  1  held zero flag
- resp_overflow  output  1  held signed-overflow flag

## Operation
- States: EMPTY (resp_valid=0), FULL (resp_valid=1).
- can_accept = !resp_valid || resp_ready (combinational; permits drain and refill in the same cycle).
- Grant: only one valid -> that one; both valid -> requester named by prio pointer.
- reqN_ready = can_accept && grant==N; ready never asserted to both; ready may depend on valid (combinational grant).
- Pointer update on accepted transfer: prio <= ~granted_id; unchanged when no transfer.
- Selected operands/ctrl drive the ALU combinationally; on transfer, result/zero/overflow/id load into the response register and resp_valid<=1.
- ALU behaviour (required): ctrl 2'b00 -> result = op1+op2 mod 2^32, zero = (result==0), overflow = (op1[31]==op2[31]) && (result[31]!=op1[31]). Other ctrl -> result 0, zero 0, overflow 0 (still a valid response).
- EMPTY -> FULL on transfer; FULL -> EMPTY on resp_ready with no new transfer; FULL -> FULL with new data on resp_ready plus transfer.
- Response fields stable while resp_valid && !resp_ready.
- Requesters must hold op/ctrl stable while valid && !ready; block does not check.

## Timing
- Reset (async assert, sync-safe deassert via clk): resp_valid=0, resp_result=0, resp_zero=0, resp_overflow=0, resp_id=0, prio=PRIO_INIT; reqN_ready follow combinationally (grant rule with resp_valid=0).
- Latency: transfer in cycle N -> resp_valid and data visible cycle N+1.
- Throughput: one op per cycle while resp_ready held high.
- Backpressure: resp_ready low in FULL -> both readies low.
- Reset mid-operation: held response discarded, no response after reset for pre-reset transfers.
- Fairness: with both valid continuously and resp_ready=1, grants alternate every cycle.

## Structure
- Shared package: ALU ctrl encodings (ALU_ADD = 2'b00), ALU data width 32, requester id constants.
- Sub-module: one instance of the existing ALU module ysyx_23060187_ALU, ctrl fed from the grant mux; arbiter logic and response register local to this block.

## Test plan
- Reset, req0 only: op1=32'h0000_0005, op2=32'h0000_0003, ctrl=00 -> next cycle resp_valid=1, id=0, result=8, zero=0, overflow=0.
- Overflow/zero: op1=32'h7FFF_FFFF+op2=1 -> result 32'h8000_0000, overflow=1; op1=32'hFFFF_FFFF+op2=1 -> result 0, zero=1, overflow=0.
- Both valid every cycle, resp_ready=1, PRIO_INIT=0 -> resp_id sequence 0,1,0,1…; never both readies high.
- resp_ready=0 for 3 cycles while FULL -> readies low, response fields unchanged; resp_ready=1 with req1 valid -> drain and refill same cycle, no bubble.
- ctrl=2'b11, any operands -> result 0, zero 0, overflow 0, resp_valid=1.
- Assert rst_n low while FULL -> resp_valid=0 immediately (asynchronous), prio=PRIO_INIT after release.

Source files
------------

// File: rtl/ysyx_23060187_alu_arbiter_pkg.sv
// Shared constants and types for the ALU arbiter slice.
// ALU ctrl encodings, data width, requester ids, FSM state, response bundle.
package ysyx_23060187_alu_arbiter_pkg;

  localparam int ALU_W      = 32;
  localparam int ALU_CTRL_W = 2;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 2'b00;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic             id;
    logic [ALU_W-1:0] result;
    logic             zero;
    logic             ovf;
  } resp_t;

endpackage

// File: rtl/ysyx_23060187_alu_arbiter_if.sv
// Handshake bundle between two ALU requesters, the arbiter and its consumer.
// slave: arbiter side; master: requester/consumer side.
interface ysyx_23060187_alu_arbiter_if;
  import ysyx_23060187_alu_arbiter_pkg::*;

  logic                  req0_valid;
  logic                  req0_ready;
  logic [ALU_W-1:0]      req0_op1;
  logic [ALU_W-1:0]      req0_op2;
  logic [ALU_CTRL_W-1:0] req0_ctrl;

  logic                  req1_valid;
  logic                  req1_ready;
  logic [ALU_W-1:0]      req1_op1;
  logic [ALU_W-1:0]      req1_op2;
  logic [ALU_CTRL_W-1:0] req1_ctrl;

  logic                  resp_valid;
  logic                  resp_ready;
  logic                  resp_id;
  logic [ALU_W-1:0]      resp_result;
  logic                  resp_zero;
  logic                  resp_overflow;

  modport slave (
    input  req0_valid, req0_op1, req0_op2, req0_ctrl,
    input  req1_valid, req1_op1, req1_op2, req1_ctrl,
    output req0_ready, req1_ready,
    output resp_valid, resp_id, resp_result,
    output resp_zero, resp_overflow,
    input  resp_ready
  );

  modport master (
    output req0_valid, req0_op1, req0_op2, req0_ctrl,
    output req1_valid, req1_op1, req1_op2, req1_ctrl,
    input  req0_ready, req1_ready,
    input  resp_valid, resp_id, resp_result,
    input  resp_zero, resp_overflow,
    output resp_ready
  );

endinterface

// File: rtl/ysyx_23060187_alu_arbiter_alu.sv
// Shared 32-bit ALU: add with zero/signed-overflow flags, null op otherwise.
// Ports: i_op1, i_op2, i_ctrl in; o_result, o_zero, o_overflow out.
module ysyx_23060187_ALU
  import ysyx_23060187_alu_arbiter_pkg::*;
(
  input  logic [ALU_W-1:0]      i_op1,
  input  logic [ALU_W-1:0]      i_op2,
  input  logic [ALU_CTRL_W-1:0] i_ctrl,
  output logic [ALU_W-1:0]      o_result,
  output logic                  o_zero,
  output logic                  o_overflow
);

  logic [ALU_W-1:0] w_sum;

  assign w_sum = i_op1 + i_op2;

  always_comb begin
    o_result   = '0;
    o_zero     = 1'b0;
    o_overflow = 1'b0;
    if (i_ctrl == ALU_ADD) begin
      o_result   = w_sum;
      o_zero     = (w_sum == '0);
      // same-sign operands producing opposite-sign sum
      o_overflow = (i_op1[ALU_W-1] == i_op2[ALU_W-1])
                && (w_sum[ALU_W-1] != i_op1[ALU_W-1]);
    end
  end

endmodule

// File: rtl/ysyx_23060187_alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one-entry response reg.
// Ports: clk, rst_n (async active-low), bus (slave modport of the arbiter interface).
module ysyx_23060187_alu_arbiter
  import ysyx_23060187_alu_arbiter_pkg::*;
#(
  parameter bit PRIO_INIT = 1'b0
)(
  input  logic clk,
  input  logic rst_n,
  ysyx_23060187_alu_arbiter_if.slave bus
);

  arb_state_t r_state;
  logic       r_prio;
  resp_t      r_resp;

  logic                  w_can_accept;
  logic                  w_gnt;
  logic                  w_rdy0;
  logic                  w_rdy1;
  logic                  w_xfer;
  logic [ALU_W-1:0]      w_op1;
  logic [ALU_W-1:0]      w_op2;
  logic [ALU_CTRL_W-1:0] w_ctrl;
  logic [ALU_W-1:0]      w_result;
  logic                  w_zero;
  logic                  w_ovf;

  // drain and refill may happen in the same cycle
  assign w_can_accept = (r_state == ST_EMPTY) || bus.resp_ready;

  always_comb begin
    w_gnt = r_prio;
    unique case ({bus.req1_valid, bus.req0_valid})
      2'b01:   w_gnt = REQ0;
      2'b10:   w_gnt = REQ1;
      2'b11:   w_gnt = r_prio;
      default: w_gnt = r_prio;
    endcase
  end

  assign w_rdy0 = w_can_accept && (w_gnt == REQ0);
  assign w_rdy1 = w_can_accept && (w_gnt == REQ1);

  assign bus.req0_ready = w_rdy0;
  assign bus.req1_ready = w_rdy1;

  assign w_xfer = (bus.req0_valid && w_rdy0)
               || (bus.req1_valid && w_rdy1);

  assign w_op1  = (w_gnt == REQ1) ? bus.req1_op1  : bus.req0_op1;
  assign w_op2  = (w_gnt == REQ1) ? bus.req1_op2  : bus.req0_op2;
  assign w_ctrl = (w_gnt == REQ1) ? bus.req1_ctrl : bus.req0_ctrl;

  ysyx_23060187_ALU u_alu (
    .i_op1      (w_op1),
    .i_op2      (w_op2),
    .i_ctrl     (w_ctrl),
    .o_result   (w_result),
    .o_zero     (w_zero),
    .o_overflow (w_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_prio  <= PRIO_INIT;
      r_resp  <= '0;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_xfer) r_state <= ST_FULL;
        end
        ST_FULL: begin
          if (!w_xfer && bus.resp_ready) r_state <= ST_EMPTY;
        end
        default: r_state <= ST_EMPTY;
      endcase
      if (w_xfer) begin
        r_prio        <= ~w_gnt;
        r_resp.id     <= w_gnt;
        r_resp.result <= w_result;
        r_resp.zero   <= w_zero;
        r_resp.ovf    <= w_ovf;
      end
    end
  end

  assign bus.resp_valid    = (r_state == ST_FULL);
  assign bus.resp_id       = r_resp.id;
  assign bus.resp_result   = r_resp.result;
  assign bus.resp_zero     = r_resp.zero;
  assign bus.resp_overflow = r_resp.ovf;

endmodule
